aes_key_store: RTL and testbench

//   Parametrised simple-dual-port store for AES round keys and state blocks.

---
 rtl/aes_key_store.sv | 164 ++++++++++++++++
 tb/tb_aes_key_store.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_store.sv
// Simple-dual-port round-key store with byte-enable writes and a zeroize sweep.
// Optional per-byte even parity is built when PARITY_EN is defined.
module aes_key_store #(
  parameter int D_WIDTH = 128,
  parameter int A_WIDTH = 4,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [A_WIDTH-1:0]   wr_addr,
  input  logic [D_WIDTH-1:0]   wr_data,
  input  logic [D_WIDTH/8-1:0] wr_be,
  input  logic                 rd_en,
  input  logic [A_WIDTH-1:0]   rd_addr,
  output logic [D_WIDTH-1:0]   rd_data,
  output logic                 rd_valid,
  output logic                 rd_perr,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done
);

  localparam int A_MAX = 2**A_WIDTH;
  localparam int NB    = D_WIDTH/8;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [A_WIDTH-1:0] ptr_q;
  logic [A_WIDTH-1:0] ptr_d;
  logic               busy_d;
  logic               done_d;

  logic               port_ok;
  logic               wr_ok;
  logic               rd_ok;
  logic               perr_now;

  logic [D_WIDTH-1:0] mem [A_MAX];

  // a clear request wins over port traffic on the same edge
  assign port_ok = (state_q == IDLE) && !clr_req;
  assign wr_ok   = port_ok && wr_en;
  assign rd_ok   = port_ok && rd_en;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + A_WIDTH'(1);
        if (ptr_q == '1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      busy     <= 1'b1;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy     <= busy_d;
      clr_done <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

`ifdef PARITY_EN
  logic [NB-1:0] par_mem [A_MAX];

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      par_mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) par_mem[wr_addr][i] <= ^wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    perr_now = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((^mem[rd_addr][8*i +: 8]) != par_mem[rd_addr][i]) perr_now = 1'b1;
    end
  end
`else
  assign perr_now = 1'b0;
`endif

  logic [D_WIDTH-1:0] d1;
  logic               v1;
  logic               p1;

  // first stage samples the array before this edge's write lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      v1 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) begin
        d1 <= mem[rd_addr];
        p1 <= perr_now;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
          rd_perr  <= 1'b0;
        end else begin
          rd_valid <= v1;
          if (v1) begin
            rd_data <= d1;
            rd_perr <= p1;
          end
        end
      end
    end else begin : g_lat1
      assign rd_data  = d1;
      assign rd_valid = v1;
      assign rd_perr  = p1;
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_store.sv
// Bench for aes_key_store: one instance per read latency, shared stimulus,
// queue-based expectations checked as each read returns.
module tb_aes_key_store;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic [15:0]  wr_be = '0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_addr = '0;
  logic         clr_req = 1'b0;

  logic [127:0] rd_data1, rd_data2;
  logic         rd_valid1, rd_valid2;
  logic         rd_perr1, rd_perr2;
  logic         busy1, busy2;
  logic         clr_done1, clr_done2;

  aes_key_store #(.D_WIDTH(128), .A_WIDTH(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_perr(rd_perr1),
    .clr_req(clr_req), .busy(busy1), .clr_done(clr_done1)
  );

  aes_key_store #(.D_WIDTH(128), .A_WIDTH(4), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_perr(rd_perr2),
    .clr_req(clr_req), .busy(busy2), .clr_done(clr_done2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         perr;
    int           due;
  } exp_t;

  exp_t         q1[$];
  exp_t         q2[$];
  logic [127:0] model [16];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_rd(input logic [3:0] a, input logic perr);
    exp_t e;
    e.data = model[a];
    e.perr = perr;
    e.due  = cyc + 1;
    q1.push_back(e);
    e.due  = cyc + 2;
    q2.push_back(e);
  endtask

  task automatic rd(input logic [3:0] a, input logic perr);
    rd_en   = 1'b1;
    rd_addr = a;
    push_rd(a, perr);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [127:0] d,
                    input logic [15:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    for (int i = 0; i < 16; i++) begin
      if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_all();
    for (int a = 0; a < 16; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      push_rd(4'(a), 1'b0);
      tick();
    end
    rd_en = 1'b0;
    repeat (3) tick();
  endtask

  // counts edges until clr_done; optionally hammers the ports meanwhile
  task automatic wait_clear(input int exp_n, input bit poke);
    int n = 0;
    bit held = 1'b1;
    bit done = 1'b0;
    rd_en   = poke;
    rd_addr = 4'd1;
    wr_en   = poke;
    wr_addr = 4'd4;
    wr_data = '1;
    wr_be   = '1;
    while (n < 100 && !done) begin
      tick();
      n++;
      done = clr_done1;
      if (!done && !(busy1 && busy2)) held = 1'b0;
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("sweep_len", 128'(n), 128'(exp_n));
    check("busy_hold", 128'(held), 128'd1);
    check("busy_end", {busy1, busy2}, 128'd0);
    check("done2", 128'(clr_done2), 128'd1);
    for (int k = 0; k < 16; k++) model[k] = '0;
    tick();
    check("done_pulse", {clr_done1, clr_done2}, 128'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid1) begin
        if (q1.size() == 0) begin
          check("spurious1", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          check("data1", rd_data1, e.data);
          check("perr1", 128'(rd_perr1), 128'(e.perr));
          check("lat1", 128'(cyc), 128'(e.due));
        end
      end
      if (rd_valid2) begin
        if (q2.size() == 0) begin
          check("spurious2", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = q2.pop_front();
          check("data2", rd_data2, e.data);
          check("perr2", 128'(rd_perr2), 128'(e.perr));
          check("lat2", 128'(cyc), 128'(e.due));
        end
      end
    end
  end

  initial begin
    logic [127:0] a_word;
    logic [127:0] b_word;

    repeat (2) @(negedge clk);
    check("rst_data", rd_data1 | rd_data2, 128'd0);
    check("rst_flags", {rd_valid1, rd_valid2, rd_perr1, rd_perr2,
                        clr_done1, clr_done2}, 128'd0);
    check("rst_busy", {busy1, busy2}, 128'd3);

    rst = 1'b0;
    wait_clear(16, 1'b0);
    rd_all();

    wr(4'd3, 128'h00112233_44556677_8899AABB_CCDDEEFF, '1);
    rd(4'd3, 1'b0);

    wr(4'd5, '1, '1);
    wr(4'd5, '0, 16'h00F0);
    check("be_model", model[5], 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
    rd(4'd5, 1'b0);
    wr(4'd6, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 16'h0000);
    rd(4'd6, 1'b0);

    b_word = {$urandom, $urandom, $urandom, $urandom};
    a_word = ~b_word;
    wr(4'd7, b_word, '1);
    wr_en   = 1'b1;
    wr_addr = 4'd7;
    wr_data = a_word;
    wr_be   = '1;
    rd_en   = 1'b1;
    rd_addr = 4'd7;
    push_rd(4'd7, 1'b0);
    model[7] = a_word;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rd(4'd7, 1'b0);
    repeat (3) tick();

`ifdef PARITY_EN
    wr(4'd9, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, '1);
    tick();
    dut.par_mem[9][0]  = ~dut.par_mem[9][0];
    dut2.par_mem[9][0] = ~dut2.par_mem[9][0];
    rd(4'd9, 1'b1);
    rd(4'd3, 1'b0);
    repeat (3) tick();
`endif

    for (int a = 0; a < 16; a++) begin
      wr(4'(a), {$urandom, $urandom, $urandom, $urandom}, '1);
    end
    rd(4'd2, 1'b0);
    rd(4'd4, 1'b0);
    repeat (3) tick();
    clr_req = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    wr_be   = '1;
    tick();
    clr_req = 1'b0;
    wr_en   = 1'b0;
    check("clr_busy", {busy1, busy2}, 128'd3);
    wait_clear(16, 1'b1);
    rd_all();

    wr(4'd11, '1, '1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_busy", {busy1, busy2}, 128'd3);
    rst = 1'b0;
    wait_clear(16, 1'b0);
    rd(4'd11, 1'b0);
    rd(4'd0, 1'b0);
    repeat (4) tick();

    check("q1_drained", 128'(q1.size()), 128'd0);
    check("q2_drained", 128'(q2.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
